// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-side front end for the register file.
//
// Merges single-cycle results (port A) and multi-cycle results (port B) into the
// single registered regfile write port. Port B results wait in a small FIFO when
// they cannot be written right away. A starvation counter limits how many
// consecutive cycles A may win while B entries are waiting.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   a_valid/a_ready/a_rd_addr/a_data   port A result handshake and payload
//   b_valid/b_ready/b_rd_addr/b_data   port B result handshake and payload
//   load/rd_addr/rd_i             registered regfile write enable/address/data
//   chk_addr/chk_hit              hazard query: a pending write targets chk_addr
module regfile_wb_arbiter #(
  parameter int unsigned Size      = 64,
  parameter int unsigned Depth     = 2,
  parameter int unsigned MaxStarve = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd_addr,
  input  logic [Size-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd_addr,
  input  logic [Size-1:0] b_data,
  output logic            load,
  output logic [4:0]      rd_addr,
  output logic [Size-1:0] rd_i,
  input  logic [4:0]      chk_addr,
  output logic            chk_hit
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned StW  = $clog2(MaxStarve + 1);

  // FIFO storage and bookkeeping
  logic [4:0]      fifo_addr_q [Depth];
  logic [Size-1:0] fifo_data_q [Depth];
  logic [Depth-1:0] fifo_vld_q, fifo_vld_d;
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;

  // Output register
  logic            load_q;
  logic [4:0]      rd_addr_q;
  logic [Size-1:0] rd_i_q;

  logic fifo_empty, fifo_full, starved;
  logic a_acc, b_acc, a_wr, b_wr;
  logic sel_a, sel_head, sel_byp;
  logic push, pop;
  logic fifo_hit;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(Depth));
  assign starved    = (starve_q == StW'(MaxStarve)) && !fifo_empty;

  assign b_ready = rst_n & !fifo_full;
  assign a_ready = rst_n & !starved;

  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;
  // Writes to x0 are accepted but never reach the regfile.
  assign a_wr  = a_acc & (a_rd_addr != 5'd0);
  assign b_wr  = b_acc & (b_rd_addr != 5'd0);

  // Output-register priority: A, then FIFO head, then B bypass.
  assign sel_a    = a_wr;
  assign sel_head = !a_wr && !fifo_empty;
  assign sel_byp  = !a_wr && fifo_empty && b_wr;

  assign pop  = sel_head;
  assign push = b_wr && !sel_byp;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fifo_vld_d = fifo_vld_q;
    if (pop) begin
      head_d             = ptr_inc(head_q);
      fifo_vld_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d             = ptr_inc(tail_q);
      fifo_vld_d[tail_q] = 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Counts A wins while B waits; any head pop or empty FIFO clears it.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (a_wr && (starve_q != StW'(MaxStarve))) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fifo_vld_q <= '0;
      starve_q   <= '0;
      load_q     <= 1'b0;
      rd_addr_q  <= '0;
      rd_i_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fifo_vld_q <= fifo_vld_d;
      starve_q   <= starve_d;
      if (sel_a) begin
        load_q    <= 1'b1;
        rd_addr_q <= a_rd_addr;
        rd_i_q    <= a_data;
      end else if (sel_head) begin
        load_q    <= 1'b1;
        rd_addr_q <= fifo_addr_q[head_q];
        rd_i_q    <= fifo_data_q[head_q];
      end else if (sel_byp) begin
        load_q    <= 1'b1;
        rd_addr_q <= b_rd_addr;
        rd_i_q    <= b_data;
      end else begin
        load_q <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= b_rd_addr;
      fifo_data_q[tail_q] <= b_data;
    end
  end

  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (fifo_vld_q[i] && (fifo_addr_q[i] == chk_addr)) begin
        fifo_hit = 1'b1;
      end
    end
  end

  assign chk_hit = (chk_addr != 5'd0) &&
                   ((load_q && (rd_addr_q == chk_addr)) || fifo_hit);

  assign load    = load_q;
  assign rd_addr = rd_addr_q;
  assign rd_i    = rd_i_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (Size=64, Depth=2, MaxStarve=4).
// Port A payloads have bit 63 clear, port B payloads have bit 63 set, so each
// observed regfile write is matched against the in-order queue of its own port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd_addr, b_rd_addr;
  logic [63:0] a_data, b_data;
  logic        load;
  logic [4:0]  rd_addr;
  logic [63:0] rd_i;
  logic [4:0]  chk_addr;
  logic        chk_hit;

  int n_checks = 0;
  int n_fails  = 0;
  int a_wr_cnt = 0;

  logic [68:0] aq[$];
  logic [68:0] bq[$];
  int          b_aseen[$];

  localparam logic [63:0] BTag = 64'h8000_0000_0000_0000;

  regfile_wb_arbiter #(
    .Size     (64),
    .Depth    (2),
    .MaxStarve(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_rd_addr(a_rd_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_rd_addr(b_rd_addr),
    .b_data   (b_data),
    .load     (load),
    .rd_addr  (rd_addr),
    .rd_i     (rd_i),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every regfile write must match the head of its port's queue.
  always @(negedge clk) begin
    logic [68:0] exp;
    if (rst_n && load) begin
      if (rd_i[63]) begin
        if (bq.size() == 0) begin
          check_eq("b_unexpected_write", 64'(rd_addr), 64'd0);
        end else begin
          exp = bq.pop_front();
          check_eq("b_wr_addr", 64'(rd_addr), 64'(exp[68:64]));
          check_eq("b_wr_data", rd_i, exp[63:0]);
          b_aseen.push_back(a_wr_cnt);
        end
      end else begin
        if (aq.size() == 0) begin
          check_eq("a_unexpected_write", 64'(rd_addr), 64'd0);
        end else begin
          exp = aq.pop_front();
          check_eq("a_wr_addr", 64'(rd_addr), 64'(exp[68:64]));
          check_eq("a_wr_data", rd_i, exp[63:0]);
          a_wr_cnt++;
        end
      end
    end
  end

  // Drive one A result at a negedge, hold until accepted; returns at the next negedge.
  task automatic send_a(input logic [4:0] addr, input logic [63:0] data);
    int waited = 0;
    a_valid = 1'b1;
    a_rd_addr = addr;
    a_data = data;
    while (!a_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!a_ready) begin
      check_eq("a_accept_timeout", 64'(waited), 64'd0);
    end else if (addr != 5'd0) begin
      aq.push_back({addr, data});
    end
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] addr, input logic [63:0] data, input bit expect_wr);
    int waited = 0;
    b_valid = 1'b1;
    b_rd_addr = addr;
    b_data = data;
    while (!b_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!b_ready) begin
      check_eq("b_accept_timeout", 64'(waited), 64'd0);
    end else if (addr != 5'd0 && expect_wr) begin
      bq.push_back({addr, data});
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a;
    int base_b;
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd_addr = '0; a_data = '0;
    b_valid = 1'b0; b_rd_addr = '0; b_data = '0;
    chk_addr = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_load", 64'(load), 64'd0);
    check_eq("rst_rd_addr", 64'(rd_addr), 64'd0);
    check_eq("rst_rd_i", rd_i, 64'd0);
    check_eq("rst_a_ready", 64'(a_ready), 64'd0);
    check_eq("rst_b_ready", 64'(b_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_a_ready", 64'(a_ready), 64'd1);
    check_eq("post_rst_b_ready", 64'(b_ready), 64'd1);

    // Single A write: visible one cycle after acceptance, then load drops
    send_a(5'd5, 64'h1234);
    check_eq("a_lat_load", 64'(load), 64'd1);
    check_eq("a_lat_addr", 64'(rd_addr), 64'd5);
    check_eq("a_lat_data", rd_i, 64'h1234);
    @(negedge clk);
    check_eq("a_load_drop", 64'(load), 64'd0);

    // B alone with empty FIFO bypasses straight to the output
    send_b(5'd7, BTag | 64'hAA, 1'b1);
    check_eq("b_byp_load", 64'(load), 64'd1);
    check_eq("b_byp_addr", 64'(rd_addr), 64'd7);
    @(negedge clk);
    check_eq("b_byp_load_drop", 64'(load), 64'd0);

    // Starvation: continuous A with B pushing 1,2,3
    base_a = a_wr_cnt;
    base_b = b_aseen.size();
    fork
      begin
        for (int i = 0; i < 16; i++) send_a(5'(10 + i), 64'(32'h100 + i));
      end
      begin
        send_b(5'd1, BTag | 64'h1, 1'b1);
        send_b(5'd2, BTag | 64'h2, 1'b1);
        send_b(5'd3, BTag | 64'h3, 1'b1);
      end
      begin
        repeat (2) @(negedge clk);
        check_eq("starve_b_ready_full", 64'(b_ready), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("starve_a_blocked", 64'(a_ready), 64'd0);
        @(negedge clk);
        check_eq("starve_a_released", 64'(a_ready), 64'd1);
        check_eq("starve_b_slot_free", 64'(b_ready), 64'd1);
      end
    join
    repeat (3) @(negedge clk);
    check_eq("starve_b_count", 64'(b_aseen.size() - base_b), 64'd3);
    if (b_aseen.size() >= base_b + 3) begin
      check_eq("starve_b1_after_a", 64'(b_aseen[base_b] - base_a), 64'd5);
      check_eq("starve_b2_after_a", 64'(b_aseen[base_b + 1] - base_a), 64'd9);
      check_eq("starve_b3_after_a", 64'(b_aseen[base_b + 2] - base_a), 64'd13);
    end

    // A to x0 while FIFO holds addr 9: the same edge pops 9
    fork
      send_a(5'd20, 64'h2020);
      send_b(5'd9, BTag | 64'h99, 1'b1);
    join
    send_a(5'd0, 64'hDEAD);
    check_eq("x0_a_pop_load", 64'(load), 64'd1);
    check_eq("x0_a_pop_addr", 64'(rd_addr), 64'd9);
    send_b(5'd0, BTag | 64'hBEEF, 1'b1);
    check_eq("x0_b_no_write", 64'(load), 64'd0);
    check_eq("x0_b_ready", 64'(b_ready), 64'd1);
    @(negedge clk);

    // Hazard query
    fork
      send_a(5'd21, 64'h2121);
      send_b(5'd12, BTag | 64'h12, 1'b1);
    join
    chk_addr = 5'd12; #1;
    check_eq("chk_fifo_hit", 64'(chk_hit), 64'd1);
    chk_addr = 5'd21; #1;
    check_eq("chk_out_hit", 64'(chk_hit), 64'd1);
    chk_addr = 5'd13; #1;
    check_eq("chk_miss", 64'(chk_hit), 64'd0);
    chk_addr = 5'd0; #1;
    check_eq("chk_x0_fifo", 64'(chk_hit), 64'd0);
    chk_addr = 5'd12;
    @(negedge clk);
    check_eq("chk_wr_load", 64'(load), 64'd1);
    check_eq("chk_wr_addr", 64'(rd_addr), 64'd12);
    check_eq("chk_wr_hit", 64'(chk_hit), 64'd1);
    chk_addr = 5'd0; #1;
    check_eq("chk_x0_out", 64'(chk_hit), 64'd0);
    chk_addr = 5'd12;
    @(negedge clk);
    check_eq("chk_after_wr", 64'(chk_hit), 64'd0);
    chk_addr = 5'd0;

    // Full FIFO, then reset mid-cycle: queued B writes must never appear
    fork
      send_a(5'd22, 64'h2222);
      send_b(5'd13, BTag | 64'h13, 1'b0);
    join
    fork
      send_a(5'd23, 64'h2323);
      send_b(5'd14, BTag | 64'h14, 1'b0);
    join
    check_eq("full_b_ready", 64'(b_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_load", 64'(load), 64'd0);
    check_eq("mid_rst_addr", 64'(rd_addr), 64'd0);
    check_eq("mid_rst_data", rd_i, 64'd0);
    check_eq("mid_rst_a_ready", 64'(a_ready), 64'd0);
    check_eq("mid_rst_b_ready", 64'(b_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rerst_b_ready", 64'(b_ready), 64'd1);
    check_eq("rerst_a_ready", 64'(a_ready), 64'd1);
    repeat (6) @(negedge clk);

    check_eq("a_queue_drained", 64'(aq.size()), 64'd0);
    check_eq("b_queue_drained", 64'(bq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
